param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file_pkg.sv | 12 +
 rtl/param_reg_file_reg_n.sv | 25 ++
 rtl/param_reg_file.sv | 91 +++++++++
 tb/tb_param_reg_file.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared constants and helpers for the parameterised register file.
package param_reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;
  localparam logic [63:0] RESET_VALUE = 64'h0;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_reg_file_reg_n.sv
// WIDTH-bit storage register with write enable and synchronous active-low reset.
module reg_n
  import param_reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // storage update: reset clears, write enable loads, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VALUE[WIDTH-1:0];
    end else if (we) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Register file with per-register pending (scoreboard) bits and a pending count.
// Optional write-to-read bypass enabled by defining PARAM_REG_FILE_BYPASS_EN.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             pend_a,
  output logic             pend_b,
  output logic [AW:0]      pend_cnt
);

`ifdef PARAM_REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] q_s [DEPTH];
  logic [DEPTH-1:0] we_s;
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [AW:0]      cnt_nxt_s;
  logic [AW:0]      pend_cnt_r;
  logic             zero_a_s, zero_b_s, hit_a_s, hit_b_s, rsv_w_s;

  // per-register write enables and next pending bits; reserve beats write-clear
  always_comb begin
    we_s       = {DEPTH{1'b0}};
    pend_nxt_s = {DEPTH{1'b0}};
    cnt_nxt_s  = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      we_s[i]       = wen && (waddr == AW'(i)) && !(HAS_ZERO && (i == 0));
      pend_nxt_s[i] = (rsv_en && (rsv_addr == AW'(i))) ? 1'b1 :
                      (wen && (waddr == AW'(i)))       ? 1'b0 : pend_r[i];
      pend_nxt_s[i] = (HAS_ZERO && (i == 0)) ? 1'b0 : pend_nxt_s[i];
      cnt_nxt_s     = cnt_nxt_s + {{AW{1'b0}}, pend_nxt_s[i]};
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    reg_n #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .we  (we_s[g]),
      .d   (wdata),
      .q   (q_s[g])
    );
  end

  // pending bits and their population count, updated together
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_r     <= {DEPTH{1'b0}};
      pend_cnt_r <= {(AW+1){1'b0}};
    end else begin
      pend_r     <= pend_nxt_s;
      pend_cnt_r <= cnt_nxt_s;
    end
  end

  assign zero_a_s = HAS_ZERO && (raddr_a == {AW{1'b0}});
  assign zero_b_s = HAS_ZERO && (raddr_b == {AW{1'b0}});
  assign hit_a_s  = BYPASS && wen && (raddr_a == waddr);
  assign hit_b_s  = BYPASS && wen && (raddr_b == waddr);
  assign rsv_w_s  = rsv_en && (rsv_addr == waddr);

  // zero register masks everything, then bypass, then array contents
  assign rdata_a  = zero_a_s ? {WIDTH{1'b0}} : hit_a_s ? wdata : q_s[raddr_a];
  assign rdata_b  = zero_b_s ? {WIDTH{1'b0}} : hit_b_s ? wdata : q_s[raddr_b];
  assign pend_a   = zero_a_s ? 1'b0 : hit_a_s ? rsv_w_s : pend_r[raddr_a];
  assign pend_b   = zero_b_s ? 1'b0 : hit_b_s ? rsv_w_s : pend_r[raddr_b];
  assign pend_cnt = pend_cnt_r;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed self-checking bench for param_reg_file (WIDTH=16, DEPTH=16, ZERO_REG=1).
module tb_param_reg_file;

  logic        clk = 1'b0;
  logic        rst, wen, rsv_en;
  logic [3:0]  waddr, rsv_addr, raddr_a, raddr_b;
  logic [15:0] wdata, rdata_a, rdata_b;
  logic        pend_a, pend_b;
  logic [4:0]  pend_cnt;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  param_reg_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .pend_a(pend_a), .pend_b(pend_b),
    .pend_cnt(pend_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    wen = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wen = 1'b1; waddr = 4'd2; wdata = 16'hAAAA; rsv_en = 1'b1; rsv_addr = 4'd2;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(15 - i);
      #1;
      tests_run++;
      if (rdata_a !== 16'h0 || pend_a !== 1'b0 || rdata_b !== 16'h0 || pend_b !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_read addr=%0d got a=%h/%b b=%h/%b want 0000/0", i, rdata_a, pend_a, rdata_b, pend_b);
      end
    end
    tests_run++;
    if (pend_cnt !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt got %0d want 0", pend_cnt);
    end
  endtask

  task automatic test_write_read();
    wen = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; raddr_a = 4'd5; raddr_b = 4'd6;
    #1;
`ifdef PARAM_REG_FILE_BYPASS_EN
    tests_run++;
    if (rdata_a !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle got %h want beef", rdata_a);
    end
`else
    tests_run++;
    if (rdata_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL pre_edge_read got %h want 0000", rdata_a);
    end
`endif
    tick();
    tests_run++;
    if (rdata_a !== 16'hBEEF || rdata_b !== 16'h0000 || pend_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_read got a=%h b=%h pa=%b want beef 0000 0", rdata_a, rdata_b, pend_a);
    end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 4'd3; tick();
    tests_run++;
    if (pend_cnt !== 5'd1) begin tests_failed++; $display("FAIL rsv_cnt1 got %0d want 1", pend_cnt); end
    rsv_en = 1'b1; rsv_addr = 4'd7; tick();
    tests_run++;
    if (pend_cnt !== 5'd2) begin tests_failed++; $display("FAIL rsv_cnt2 got %0d want 2", pend_cnt); end
    wen = 1'b1; waddr = 4'd3; wdata = 16'h0033; tick();
    raddr_a = 4'd3; raddr_b = 4'd7; #1;
    tests_run++;
    if (pend_cnt !== 5'd1 || pend_a !== 1'b0 || pend_b !== 1'b1 || rdata_a !== 16'h0033) begin
      tests_failed++;
      $display("FAIL rsv_write got cnt=%0d pa=%b pb=%b a=%h want 1 0 1 0033", pend_cnt, pend_a, pend_b, rdata_a);
    end
    rsv_en = 1'b1; rsv_addr = 4'd7; tick();
    tests_run++;
    if (pend_cnt !== 5'd1 || pend_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL double_rsv got cnt=%0d pb=%b want 1 1", pend_cnt, pend_b);
    end
    wen = 1'b1; waddr = 4'd5; wdata = 16'h5555; tick();
    raddr_a = 4'd5; #1;
    tests_run++;
    if (pend_cnt !== 5'd1 || pend_a !== 1'b0 || rdata_a !== 16'h5555) begin
      tests_failed++;
      $display("FAIL write_nonpend got cnt=%0d pa=%b a=%h want 1 0 5555", pend_cnt, pend_a, rdata_a);
    end
  endtask

  task automatic test_same_cycle();
    wen = 1'b1; waddr = 4'd4; wdata = 16'h1234; rsv_en = 1'b1; rsv_addr = 4'd4; raddr_a = 4'd4;
`ifdef PARAM_REG_FILE_BYPASS_EN
    #1;
    tests_run++;
    if (rdata_a !== 16'h1234 || pend_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_rsv got a=%h pa=%b want 1234 1", rdata_a, pend_a);
    end
`endif
    tick();
    raddr_b = 4'd4; #1;
    tests_run++;
    if (rdata_a !== 16'h1234 || pend_a !== 1'b1 || pend_cnt !== 5'd2 || rdata_b !== 16'h1234 || pend_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle got a=%h pa=%b cnt=%0d b=%h pb=%b want 1234 1 2 1234 1", rdata_a, pend_a, pend_cnt, rdata_b, pend_b);
    end
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    raddr_a = 4'd0; raddr_b = 4'd0;
    #1;
    tests_run++;
    if (rdata_a !== 16'h0 || pend_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_same_cycle got a=%h pa=%b want 0000 0", rdata_a, pend_a);
    end
    tick();
    tests_run++;
    if (rdata_a !== 16'h0 || pend_a !== 1'b0 || rdata_b !== 16'h0 || pend_b !== 1'b0 || pend_cnt !== 5'd2) begin
      tests_failed++;
      $display("FAIL zero_reg got a=%h pa=%b b=%h pb=%b cnt=%0d want 0000 0 0000 0 2", rdata_a, pend_a, rdata_b, pend_b, pend_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rlist [5];
    rlist = '{4'd1, 4'd2, 4'd8, 4'd9, 4'd10};
    for (int i = 0; i < 5; i++) begin
      rsv_en = 1'b1; rsv_addr = rlist[i]; tick();
    end
    tests_run++;
    if (pend_cnt !== 5'd7) begin tests_failed++; $display("FAIL pre_reset_cnt got %0d want 7", pend_cnt); end
    rst = 1'b0; wen = 1'b1; waddr = 4'd11; wdata = 16'h7777; rsv_en = 1'b1; rsv_addr = 4'd11;
    tick();
    rst = 1'b1;
    tests_run++;
    if (pend_cnt !== 5'd0) begin tests_failed++; $display("FAIL mid_reset_cnt got %0d want 0", pend_cnt); end
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); #1;
      tests_run++;
      if (rdata_a !== 16'h0 || pend_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_read addr=%0d got %h/%b want 0000/0", i, rdata_a, pend_a);
      end
    end
    rsv_en = 1'b1; rsv_addr = 4'd2; tick();
    raddr_a = 4'd2; #1;
    tests_run++;
    if (pend_cnt !== 5'd1 || pend_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_rsv got cnt=%0d pa=%b want 1 1", pend_cnt, pend_a);
    end
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; rsv_en = 1'b0; waddr = 4'd0; rsv_addr = 4'd0;
    wdata = 16'h0; raddr_a = 4'd0; raddr_b = 4'd0;
    test_reset();
    test_write_read();
    test_reserve();
    test_same_cycle();
    test_zero_reg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
